// File: rtl/epu_out_writer_if.sv
// sp_ram_intf: single-port SRAM bus shared by the output-buffer wrapper and its masters
interface sp_ram_intf #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          cs;
  logic          oe;
  logic          W_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] W_data;
  logic [DW-1:0] R_data;
  modport master (output cs, oe, addr, W_req, W_data, input R_data);
  modport slave  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/epu_out_writer.sv
// epu_out_writer: claims the output SRAM, writes a job's result stream to consecutive addresses, then releases it
module epu_out_writer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [ADDR_W:0]   cfg_len_i,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              start_o,
  output logic              finish_o,
  output logic              done_o,
  output logic              busy_o,
  sp_ram_intf.master        mem
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, WRITE = 2'd2, FIN = 2'd3;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [PW:0] C1 = (PW+1)'(1);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len, acc, wr;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       cnt;
  logic              push, pop, last, cfg_hs;
  assign cfg_ready_o = state == IDLE;
  assign start_o     = state != IDLE;
  assign busy_o      = start_o;
  assign finish_o    = state == FIN;
  assign done_o      = finish_o;
  assign cfg_hs      = cfg_valid_i & cfg_ready_o;
  assign res_ready_o = (state == ARM || state == WRITE) && cnt != FULL && acc < len;
  assign push        = res_valid_i & res_ready_o;
  assign pop         = state == WRITE && cnt != '0;
  assign last        = pop && (wr + ONE) == len;
  always_comb begin
    state_nx = state == IDLE  ? (cfg_valid_i ? ARM : IDLE) :
               state == ARM   ? (len == '0 ? FIN : WRITE) :
               state == WRITE ? (last ? FIN : WRITE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base   <= '0;
      len    <= '0;
      acc    <= '0;
      wr     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (cfg_hs) begin
        base   <= cfg_base_i;
        len    <= cfg_len_i;
        acc    <= '0;
        wr     <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          acc    <= acc + ONE;
          wr_ptr <= wr_ptr + P1;
        end
        if (pop) begin
          wr     <= wr + ONE;
          rd_ptr <= rd_ptr + P1;
        end
        cnt <= (push && !pop) ? cnt + C1 : (!push && pop) ? cnt - C1 : cnt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= res_data_i;
  end
  // Bus sits at idle values in every cycle that does not pop a word.
  always_comb begin
    mem.cs     = pop;
    mem.oe     = 1'b0;
    mem.W_req  = pop ? WRITE_ENB : WRITE_DIS;
    mem.addr   = '0;
    mem.W_data = '0;
    mem.addr[ADDR_W-1:0]   = pop ? base + wr[ADDR_W-1:0] : '0;
    mem.W_data[DATA_W-1:0] = pop ? fifo[rd_ptr] : '0;
  end
endmodule

// File: tb/tb_epu_out_writer.sv
// tb_epu_out_writer: directed checks of the output writer's job sequencing and SRAM bus
module tb_epu_out_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid_i, cfg_ready_o;
  logic [15:0] cfg_base_i;
  logic [16:0] cfg_len_i;
  logic        res_valid_i, res_ready_o;
  logic [31:0] res_data_i;
  logic        start_o, finish_o, done_o, busy_o;
  int          checks = 0;
  int          errors = 0;
  int          acc, wrs, dn, off;
  always #5 clk = ~clk;
  sp_ram_intf #(.AW(16), .DW(32)) mem ();
  assign mem.R_data = '0;
  epu_out_writer #(.DATA_W(32), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .start_o(start_o), .finish_o(finish_o), .done_o(done_o), .busy_o(busy_o),
    .mem(mem)
  );
  // status = {start, finish, done, busy, cfg_ready, res_ready}
  function automatic logic [5:0] st();
    return {start_o, finish_o, done_o, busy_o, cfg_ready_o, res_ready_o};
  endfunction
  function automatic logic [50:0] bus();
    return {mem.cs, mem.oe, mem.W_req, mem.addr, mem.W_data};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [31:0] d);
    chk(tag, bus(), {1'b1, 1'b0, 1'b1, a, d});
  endtask
  task automatic chk_idle(input string tag);
    chk(tag, bus(), 51'd0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [15:0] b, input logic [16:0] l);
    cfg_valid_i = 1'b1;
    cfg_base_i  = b;
    cfg_len_i   = l;
    chk("cfg_ready", cfg_ready_o, 1);
    tick();
    cfg_valid_i = 1'b0;
  endtask
  initial begin
    cfg_valid_i = 1'b0;
    cfg_base_i  = '0;
    cfg_len_i   = '0;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    tick();
    tick();
    chk("rst_status", st(), 6'b000010);
    chk_idle("rst_bus");
    rst_n = 1'b1;
    tick();
    // basic job
    cfg(16'h0100, 17'd4);
    res_valid_i = 1'b1;
    res_data_i  = 32'hA0;
    chk("b_arm", st(), 6'b100101);
    chk_idle("b_arm_bus");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_wr($sformatf("b_wr%0d", k), 16'h0100 + 16'(k), 32'hA0 + 32'(k));
      chk($sformatf("b_st%0d", k), st() & 6'b111000, 6'b100000);
      res_data_i  = 32'hA1 + 32'(k);
      res_valid_i = (k < 3);
    end
    tick();
    chk("b_fin", st(), 6'b111100);
    chk_idle("b_fin_bus");
    tick();
    chk("b_idle", st(), 6'b000010);
    // gapped input
    cfg(16'h0200, 17'd3);
    res_valid_i = 1'b1;
    res_data_i  = 32'hB0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_wr($sformatf("g_wr%0d", j), 16'h0200 + 16'(j), 32'hB0 + 32'(j));
      res_valid_i = 1'b0;
      tick();
      if (j < 2) begin
        chk_idle($sformatf("g_gap%0d", j));
        res_valid_i = 1'b1;
        res_data_i  = 32'hB1 + 32'(j);
      end else chk("g_fin", st(), 6'b111100);
    end
    tick();
    chk("g_idle", st(), 6'b000010);
    // over-supply: six words offered to a four-word job
    cfg(16'h0300, 17'd4);
    acc = 0; wrs = 0; dn = 0; off = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem.cs) begin
        chk_wr($sformatf("o_wr%0d", wrs), 16'h0300 + 16'(wrs), 32'hC0 + 32'(wrs));
        wrs++;
      end
      if (done_o) dn++;
      res_valid_i = (off < 6);
      res_data_i  = 32'hC0 + 32'(acc);
      if (acc == 4) chk($sformatf("o_rdy_low%0d", c), res_ready_o, 0);
      if (res_valid_i && res_ready_o) acc++;
      if (res_valid_i) off++;
      tick();
    end
    res_valid_i = 1'b0;
    chk("o_accepted", 64'(acc), 4);
    chk("o_writes", 64'(wrs), 4);
    chk("o_done", 64'(dn), 1);
    // zero length
    cfg(16'h0400, 17'd0);
    res_valid_i = 1'b1;
    res_data_i  = 32'hDEAD;
    chk("z_arm", st(), 6'b100100);
    chk_idle("z_arm_bus");
    tick();
    chk("z_fin", st(), 6'b111100);
    chk_idle("z_fin_bus");
    tick();
    chk("z_idle", st(), 6'b000010);
    res_valid_i = 1'b0;
    // address wrap
    cfg(16'hFFFE, 17'd4);
    res_valid_i = 1'b1;
    res_data_i  = 32'hD0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_wr($sformatf("w_wr%0d", k), 16'hFFFE + 16'(k), 32'hD0 + 32'(k));
      res_data_i  = 32'hD1 + 32'(k);
      res_valid_i = (k < 3);
    end
    tick();
    chk("w_fin", st(), 6'b111100);
    tick();
    chk("w_idle", st(), 6'b000010);
    // reset mid-job after two of eight writes
    cfg(16'h0500, 17'd8);
    res_valid_i = 1'b1;
    res_data_i  = 32'h50;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_wr($sformatf("r_wr%0d", k), 16'h0500 + 16'(k), 32'h50 + 32'(k));
      res_data_i = 32'h51 + 32'(k);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("r_status", st(), 6'b000010);
    chk_idle("r_bus");
    res_valid_i = 1'b0;
    tick();
    chk("r_hold", st(), 6'b000010);
    rst_n = 1'b1;
    tick();
    chk("r_after", st(), 6'b000010);
    cfg(16'h0010, 17'd2);
    res_valid_i = 1'b1;
    res_data_i  = 32'hF0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_wr($sformatf("p_wr%0d", k), 16'h0010 + 16'(k), 32'hF0 + 32'(k));
      res_data_i  = 32'hF1 + 32'(k);
      res_valid_i = (k < 1);
    end
    tick();
    chk("p_fin", st(), 6'b111100);
    tick();
    chk("p_idle", st(), 6'b000010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
